// File: rtl/rgmii_rx_frame_parser.sv
// Receive framer behind the RGMII capture stage: preamble/SFD hunt, FCS strip with CRC-32 residue check,
// length and rxer checks, payload beats with sof/eof/err markers, and saturating good/bad frame counters.
module rgmii_rx_frame_parser #(
   parameter int MIN_LEN   = 64,
   parameter int MAX_LEN   = 1518,
   parameter bit CHECK_FCS = 1'b1,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             I_rst_n,
   input  logic [7:0]       I_rxd,
   input  logic             I_rxdv,
   input  logic             I_rxer,
   output logic [7:0]       O_data,
   output logic             O_valid,
   output logic             O_sof,
   output logic             O_eof,
   output logic             O_err,
   output logic [CNT_W-1:0] O_good_cnt,
   output logic [CNT_W-1:0] O_bad_cnt,
   output logic [2:0]       O_dbg_state
);

   // Handshake: there is no back-pressure. O_valid is a one-cycle pulse per payload byte and the
   // consumer must take O_data/O_sof/O_eof/O_err in that cycle; O_err is qualified by O_eof.

   typedef enum logic [2:0] {
      S_WAIT_IDLE = 3'd0,
      S_IDLE      = 3'd1,
      S_PREAMBLE  = 3'd2,
      S_DATA      = 3'd3,
      S_DROP      = 3'd4
   } state_t;

   localparam logic [7:0]  PRE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE = 8'hD5;
   localparam logic [31:0] CRC_POLY = 32'hEDB88320;
   localparam logic [31:0] CRC_RES  = 32'hDEBB20E3;
   localparam logic [15:0] MIN_L    = 16'(MIN_LEN);
   localparam logic [15:0] MAX_L    = 16'(MAX_LEN);
   localparam logic [15:0] LAT      = 16'd5;

   state_t                state_q, state_d;
   logic [3:0]            pre_cnt_q, pre_cnt_d;
   logic [31:0]           crc_q, crc_d;
   logic [15:0]           cnt_q, cnt_d;
   logic [4:0][7:0]       dly_q, dly_d;
   logic                  rxer_q, rxer_d;
   logic [7:0]            data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  sof_q, sof_d;
   logic                  eof_q, eof_d;
   logic                  err_q, err_d;
   logic [CNT_W-1:0]      good_q, good_d;
   logic [CNT_W-1:0]      bad_q, bad_d;
   logic                  frame_bad;
   logic                  crc_bad;

   function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h000000, d};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
      end
      return r;
   endfunction

   // State register
   always_ff @(posedge clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state_q <= S_WAIT_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_WAIT_IDLE: begin
            if (!I_rxdv) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (I_rxdv) state_d = (I_rxd == PRE_BYTE) ? S_PREAMBLE : S_DROP;
         end
         S_PREAMBLE: begin
            if (!I_rxdv) begin
               state_d = S_IDLE;
            end else if (I_rxd == PRE_BYTE) begin
               // pre_cnt_q already counts the 55 seen in IDLE; a 16th one is not a preamble
               state_d = (pre_cnt_q == 4'd15) ? S_DROP : S_PREAMBLE;
            end else if (I_rxd == SFD_BYTE) begin
               state_d = S_DATA;
            end else begin
               state_d = S_DROP;
            end
         end
         S_DATA: begin
            if (!I_rxdv) state_d = S_IDLE;
         end
         S_DROP: begin
            if (!I_rxdv) state_d = S_IDLE;
         end
         default: state_d = S_WAIT_IDLE;
      endcase
   end

   assign crc_bad   = CHECK_FCS && (crc_q != CRC_RES);
   assign frame_bad = crc_bad || (cnt_q < MIN_L) || (cnt_q > MAX_L) || rxer_q;

   // Output and datapath logic
   always_comb begin
      pre_cnt_d = pre_cnt_q;
      crc_d     = crc_q;
      cnt_d     = cnt_q;
      dly_d     = dly_q;
      rxer_d    = rxer_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      sof_d     = 1'b0;
      eof_d     = 1'b0;
      err_d     = 1'b0;
      good_d    = good_q;
      bad_d     = bad_q;
      case (state_q)
         S_IDLE: begin
            pre_cnt_d = 4'd1;
         end
         S_PREAMBLE: begin
            if (I_rxdv && (I_rxd == PRE_BYTE)) begin
               pre_cnt_d = pre_cnt_q + 4'd1;
            end else if (I_rxdv && (I_rxd == SFD_BYTE)) begin
               crc_d  = 32'hFFFFFFFF;
               cnt_d  = 16'd0;
               rxer_d = 1'b0;
            end
         end
         S_DATA: begin
            if (I_rxdv) begin
               crc_d = crc_next(crc_q, I_rxd);
               cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
               dly_d = {dly_q[3:0], I_rxd};
               if (I_rxer) rxer_d = 1'b1;
               // The oldest delay-line byte leaves as soon as five bytes sit behind it
               if (cnt_q >= LAT) begin
                  valid_d = 1'b1;
                  data_d  = dly_q[4];
                  sof_d   = (cnt_q == LAT);
               end
            end else if (cnt_q >= LAT) begin
               valid_d = 1'b1;
               data_d  = dly_q[4];
               sof_d   = (cnt_q == LAT);
               eof_d   = 1'b1;
               err_d   = frame_bad;
               if (frame_bad) begin
                  bad_d = (&bad_q) ? bad_q : bad_q + CNT_W'(1);
               end else begin
                  good_d = (&good_q) ? good_q : good_q + CNT_W'(1);
               end
            end else begin
               bad_d = (&bad_q) ? bad_q : bad_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         pre_cnt_q <= 4'd0;
         crc_q     <= 32'hFFFFFFFF;
         cnt_q     <= 16'd0;
         dly_q     <= '0;
         rxer_q    <= 1'b0;
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
         sof_q     <= 1'b0;
         eof_q     <= 1'b0;
         err_q     <= 1'b0;
         good_q    <= '0;
         bad_q     <= '0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
         crc_q     <= crc_d;
         cnt_q     <= cnt_d;
         dly_q     <= dly_d;
         rxer_q    <= rxer_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         sof_q     <= sof_d;
         eof_q     <= eof_d;
         err_q     <= err_d;
         good_q    <= good_d;
         bad_q     <= bad_d;
      end
   end

   assign O_data      = data_q;
   assign O_valid     = valid_q;
   assign O_sof       = sof_q;
   assign O_eof       = eof_q;
   assign O_err       = err_q;
   assign O_good_cnt  = good_q;
   assign O_bad_cnt   = bad_q;
   assign O_dbg_state = state_q;

endmodule

// File: tb/tb_rgmii_rx_frame_parser.sv
// Bench for rgmii_rx_frame_parser: two instances (FCS checked with 16-bit counters, FCS ignored with
// 2-bit counters) share one stimulus stream; expected beats are queued per instance and popped by monitors.
module tb_rgmii_rx_frame_parser;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #4 clk = ~clk;

   logic       rst_n;
   logic [7:0] rxd;
   logic       rxdv;
   logic       rxer;

   logic [7:0]  d0, d1;
   logic        v0, v1, s0, s1, e0, e1, r0, r1;
   logic [15:0] g0, b0;
   logic [1:0]  g1, b1;
   logic [2:0]  st0, st1;

   rgmii_rx_frame_parser u0 (
      .clk(clk), .I_rst_n(rst_n), .I_rxd(rxd), .I_rxdv(rxdv), .I_rxer(rxer),
      .O_data(d0), .O_valid(v0), .O_sof(s0), .O_eof(e0), .O_err(r0),
      .O_good_cnt(g0), .O_bad_cnt(b0), .O_dbg_state(st0)
   );

   rgmii_rx_frame_parser #(.CHECK_FCS(1'b0), .CNT_W(2)) u1 (
      .clk(clk), .I_rst_n(rst_n), .I_rxd(rxd), .I_rxdv(rxdv), .I_rxer(rxer),
      .O_data(d1), .O_valid(v1), .O_sof(s1), .O_eof(e1), .O_err(r1),
      .O_good_cnt(g1), .O_bad_cnt(b1), .O_dbg_state(st1)
   );

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_fail   = 0;
   bit          mon_en   = 1'b0;
   logic [10:0] exp_q0[$];
   logic [10:0] exp_q1[$];
   logic [7:0]  frm[0:1599];
   int          frm_len;
   int          eg0, eb0, eg1, eb1;

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      logic        fb;
      r = c;
      for (int b = 0; b < 8; b++) begin
         fb = r[0] ^ d[b];
         r  = {1'b0, r[31:1]};
         if (fb) r = r ^ 32'hEDB88320;
      end
      return r;
   endfunction

   function automatic int sat(input int v, input int maxv);
      return (v >= maxv) ? maxv : v + 1;
   endfunction

   task automatic build(input int n_pay, input int seed);
      logic [31:0] c;
      logic [31:0] fcs;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n_pay; i++) begin
         frm[i] = 8'((i * 13 + seed) ^ (i >> 3));
         c = crc_upd(c, frm[i]);
      end
      fcs = ~c;
      for (int j = 0; j < 4; j++) frm[n_pay + j] = fcs[8*j +: 8];
      frm_len = n_pay + 4;
   endtask

   // Queue the beats and counter effects of the frame currently in frm[]
   task automatic expect_frame(input bit crc_ok, input bit er);
      bit len_bad, bad0, bad1;
      len_bad = (frm_len < 64) || (frm_len > 1518);
      bad0 = !crc_ok || len_bad || er;
      bad1 = len_bad || er;
      if (frm_len < 5) begin
         eb0 = sat(eb0, 65535);
         eb1 = sat(eb1, 3);
         return;
      end
      for (int i = 0; i <= frm_len - 5; i++) begin
         exp_q0.push_back({frm[i], i == 0, i == frm_len - 5, (i == frm_len - 5) && bad0});
         exp_q1.push_back({frm[i], i == 0, i == frm_len - 5, (i == frm_len - 5) && bad1});
      end
      if (bad0) eb0 = sat(eb0, 65535); else eg0 = sat(eg0, 65535);
      if (bad1) eb1 = sat(eb1, 3);     else eg1 = sat(eg1, 3);
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [7:0] b, input logic dv, input logic er);
      @(negedge clk);
      rxd  = b;
      rxdv = dv;
      rxer = er;
   endtask

   // mode 0: pre_n x 55 then D5; mode 1: corrupt preamble 55,55,A5 then D5
   task automatic send(input int mode, input int pre_n, input int rxer_idx, input int gap);
      if (mode == 1) begin
         drive(8'h55, 1'b1, 1'b0);
         drive(8'h55, 1'b1, 1'b0);
         drive(8'hA5, 1'b1, 1'b0);
      end else begin
         repeat (pre_n) drive(8'h55, 1'b1, 1'b0);
      end
      drive(8'hD5, 1'b1, 1'b0);
      for (int i = 0; i < frm_len; i++) drive(frm[i], 1'b1, i == rxer_idx);
      repeat (gap) drive(8'h00, 1'b0, 1'b0);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic check_cnts(input string tag);
      chk({tag, " good_cnt0"}, 32'(g0), 32'(eg0[15:0]));
      chk({tag, " bad_cnt0"},  32'(b0), 32'(eb0[15:0]));
      chk({tag, " good_cnt1"}, 32'(g1), 32'(eg1[1:0]));
      chk({tag, " bad_cnt1"},  32'(b1), 32'(eb1[1:0]));
   endtask

   // ---------------- monitors ----------------
   task automatic mon_beat(input int which, input logic [7:0] d, input logic v, input logic s,
                           input logic e, input logic r);
      logic [10:0] got, exp_b;
      if (v) begin
         got = {d, s, e, e & r};
         n_checks++;
         if ((which == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
            n_fail++;
            $display("FAIL beat%0d unexpected: got {data,sof,eof,err}=%h, expected no beat", which, got);
         end else begin
            exp_b = (which == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            if (got !== exp_b) begin
               n_fail++;
               $display("FAIL beat%0d: got {data,sof,eof,err}=%h, expected %h", which, got, exp_b);
            end
         end
      end else if (s || e) begin
         n_checks++;
         n_fail++;
         $display("FAIL marker%0d: got sof=%b eof=%b with valid=0, expected 0", which, s, e);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon_beat(0, d0, v0, s0, e0, r0);
         mon_beat(1, d1, v1, s1, e1, r1);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0;
      rxd   = 8'h00;
      rxdv  = 1'b0;
      rxer  = 1'b0;
      eg0 = 0; eb0 = 0; eg1 = 0; eb1 = 0;
      repeat (3) @(negedge clk);
      chk("reset valid", 32'(v0), 32'd0);
      chk("reset sof",   32'(s0), 32'd0);
      chk("reset eof",   32'(e0), 32'd0);
      chk("reset state", 32'(st0), 32'd0);
      check_cnts("reset");
      rst_n  = 1'b1;
      mon_en = 1'b1;
      repeat (3) drive(8'h00, 1'b0, 1'b0);

      // good 64-byte frame
      build(60, 1); expect_frame(1'b1, 1'b0); send(0, 7, -1, 3);
      check_cnts("t1 good64");

      // one payload bit flipped after FCS computed
      build(60, 2); frm[10] = frm[10] ^ 8'h04; expect_frame(1'b0, 1'b0); send(0, 7, -1, 3);
      check_cnts("t2 crcbad");

      // runt with 3 bytes after SFD
      frm[0] = 8'h11; frm[1] = 8'h22; frm[2] = 8'h33; frm_len = 3;
      expect_frame(1'b1, 1'b0); send(0, 7, -1, 3);
      check_cnts("t3 runt3");

      // 40 bytes with valid FCS, below MIN_LEN
      build(36, 3); expect_frame(1'b1, 1'b0); send(0, 7, -1, 3);
      check_cnts("t3 short40");

      // 1519 bytes oversize, then exactly 1518
      build(1515, 4); expect_frame(1'b1, 1'b0); send(0, 7, -1, 3);
      check_cnts("t4 len1519");
      build(1514, 5); expect_frame(1'b1, 1'b0); send(0, 7, -1, 3);
      check_cnts("t4 len1518");

      // rxer pulse mid-frame
      build(60, 6); expect_frame(1'b1, 1'b1); send(0, 7, 30, 3);
      check_cnts("t4 rxer");

      // bad preamble byte and 16 preamble bytes are both dropped
      build(60, 7); send(1, 0, -1, 3);
      check_cnts("t5 pre55A5");
      build(60, 12); send(0, 16, -1, 3);
      check_cnts("t5 pre16");

      // 15 preamble bytes is the longest accepted preamble
      build(60, 13); expect_frame(1'b1, 1'b0); send(0, 15, -1, 3);
      check_cnts("t5 pre15");

      // back-to-back with one idle cycle
      build(60, 8); expect_frame(1'b1, 1'b0); send(0, 7, -1, 1);
      build(60, 9); expect_frame(1'b1, 1'b0); send(0, 7, -1, 3);
      check_cnts("t5 b2b");

      // reset asserted mid-frame, released while rxdv=1
      mon_en = 1'b0;
      build(60, 10);
      repeat (7) drive(8'h55, 1'b1, 1'b0);
      drive(8'hD5, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) drive(frm[i], 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      eg0 = 0; eb0 = 0; eg1 = 0; eb1 = 0;
      chk("async rst valid", 32'(v0), 32'd0);
      chk("async rst data",  32'(d0), 32'd0);
      check_cnts("async rst");
      mon_en = 1'b1;
      for (int i = 20; i < 30; i++) drive(frm[i], 1'b1, 1'b0);
      rst_n = 1'b1;
      for (int i = 30; i < frm_len; i++) drive(frm[i], 1'b1, 1'b0);
      repeat (3) drive(8'h00, 1'b0, 1'b0);
      check_cnts("t6 ignored");
      build(60, 11); expect_frame(1'b1, 1'b0); send(0, 7, -1, 4);
      check_cnts("t6 next");

      chk("queue0 drained", 32'(exp_q0.size()), 32'd0);
      chk("queue1 drained", 32'(exp_q1.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
